energy_monitor: RTL

Synthesizable per-cycle activity/energy accounting unit for the accelerator's streaming ports. It generalises the bench-side energy estimate to NB_PORTS valid/ready streams, each with its own per-transfer cost and zero-flag gating. It adds a pipelined saturating accumulator, per-port nonzero/zero transfer counters and optional fixed-length measurement windows. It sits beside the top level, tapping the handshake wires without driving them, and reports under start/stop control.

---
 rtl/energy_monitor_pkg.sv | 25 ++
 rtl/energy_monitor_sat_counter.sv | 28 ++
 rtl/energy_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/energy_monitor_pkg.sv
// energy_monitor_pkg: shared types and helpers for the energy monitor.
//   state_e     - control FSM states
//   cyc_cost_w  - width of a per-cycle summed cost
//   sat_add     - unsigned add clamped to all-ones of a given width (<= 64)
package energy_monitor_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // A cycle sum of nb_ports costs needs clog2(nb_ports+1) extra bits.
  function automatic int cyc_cost_w(input int cost_w, input int nb_ports);
    return cost_w + $clog2(nb_ports + 1);
  endfunction

  // Operands are zero-extended into 64 bits; w selects the clamp width.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? m[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/energy_monitor_sat_counter.sv
// sat_counter: saturating up-counter.
//   clk, rst  - clock, synchronous active-high reset
//   i_clr     - synchronous clear
//   i_en      - increment (ignored once the count is all-ones)
//   o_cnt     - current count
//   o_full    - count is all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_full
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr)              r_cnt <= '0;
    else if (i_en && !(&r_cnt))    r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_full = &r_cnt;

endmodule

// File: rtl/energy_monitor.sv
// energy_monitor: passive energy/activity accounting over NB_PORTS
// valid/ready streams.
//   clk, rst                      - clock, synchronous active-high reset
//   port_valid/ready/zero/cost    - tapped handshakes and per-port cost
//   window_len                    - window length in RUN cycles (0 = off)
//   start, stop, clear            - measurement control
//   running, done                 - status; done pulses with final totals
//   energy_total, saturated       - saturating total, sticky saturation
//   xfer_count, zero_count        - per-port nonzero / zero transfers
//   window_energy, window_valid   - per-window energy and its pulse
// Pipeline: s0 registers the sampled handshakes, s1 sums cycle cost and
// bumps counters, s2 accumulates energy and emits window/done pulses.
module energy_monitor
  import energy_monitor_pkg::*;
#(
  parameter int NB_PORTS     = 3,
  parameter int COST_WIDTH   = 8,
  parameter int ACC_WIDTH    = 48,  // sat_add limits this to 64
  parameter int CNT_WIDTH    = 32,
  parameter int WINDOW_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NB_PORTS-1:0]                  port_valid,
  input  logic [NB_PORTS-1:0]                  port_ready,
  input  logic [NB_PORTS-1:0]                  port_zero,
  input  logic [NB_PORTS-1:0][COST_WIDTH-1:0]  port_cost,
  input  logic [WINDOW_WIDTH-1:0]              window_len,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic                                 clear,
  output logic                                 running,
  output logic                                 done,
  output logic [ACC_WIDTH-1:0]                 energy_total,
  output logic                                 saturated,
  output logic [NB_PORTS-1:0][CNT_WIDTH-1:0]   xfer_count,
  output logic [NB_PORTS-1:0][CNT_WIDTH-1:0]   zero_count,
  output logic [ACC_WIDTH-1:0]                 window_energy,
  output logic                                 window_valid
);

  localparam int CCW = cyc_cost_w(COST_WIDTH, NB_PORTS);

  state_e                              r_state;
  logic                                r_running;
  logic [WINDOW_WIDTH-1:0]             r_win_len, r_win_cnt;
  logic [NB_PORTS-1:0]                 r_s0_fire, r_s0_zf;
  logic [NB_PORTS-1:0][COST_WIDTH-1:0] r_s0_cost;
  logic [1:0]                          r_wend_pipe, r_last_pipe;  // [0]=s0, [1]=s1
  logic [CCW-1:0]                      r_s1_cost, w_cyc;
  logic [ACC_WIDTH-1:0]                r_energy, r_win_acc, r_win_energy;
  logic [ACC_WIDTH-1:0]                w_e_sum, w_w_sum;
  logic                                r_sat, r_done, r_wv;
  logic [2*NB_PORTS-1:0]               w_full;
  logic                                w_flush, w_start_acc, w_restart;
  logic                                w_run, w_stop_acc, w_wend, w_win_on;
  logic [NB_PORTS-1:0]                 w_fire, w_zfire;

  assign w_flush     = rst | clear;
  assign w_start_acc = (r_state == IDLE) & start;
  assign w_restart   = w_flush | w_start_acc;
  assign w_run       = (r_state == RUN);
  assign w_stop_acc  = w_run & stop;
  assign w_win_on    = (r_win_len != '0);
  assign w_wend      = w_run & w_win_on & (r_win_cnt == r_win_len - WINDOW_WIDTH'(1));
  assign w_fire      = port_valid & port_ready & ~port_zero;
  assign w_zfire     = port_valid & port_ready & port_zero;

  // Control FSM; clear/rst abort without producing done.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_win_len <= '0;
      r_win_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state   <= RUN;
          r_running <= 1'b1;
          r_win_len <= window_len;
          r_win_cnt <= '0;
        end
        RUN: begin
          r_win_cnt <= w_wend ? '0 : r_win_cnt + WINDOW_WIDTH'(1);
          if (stop) r_state <= DRAIN;
        end
        DRAIN: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // s0: capture handshakes only while RUN; the stop cycle is tagged last.
  always_ff @(posedge clk) begin
    if (w_flush || !w_run) begin
      r_s0_fire      <= '0;
      r_s0_zf        <= '0;
      r_s0_cost      <= '0;
      r_wend_pipe[0] <= 1'b0;
      r_last_pipe[0] <= 1'b0;
    end else begin
      r_s0_fire      <= w_fire;
      r_s0_zf        <= w_zfire;
      for (int i = 0; i < NB_PORTS; i++)
        r_s0_cost[i] <= w_fire[i] ? port_cost[i] : '0;
      r_wend_pipe[0] <= w_wend;
      r_last_pipe[0] <= w_stop_acc;
    end
  end

  always_comb begin
    w_cyc = '0;
    for (int i = 0; i < NB_PORTS; i++)
      w_cyc = w_cyc + CCW'(r_s0_cost[i]);
  end

  // s1: registered cycle cost, tags follow.
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_s1_cost      <= '0;
      r_wend_pipe[1] <= 1'b0;
      r_last_pipe[1] <= 1'b0;
    end else begin
      r_s1_cost      <= w_cyc;
      r_wend_pipe[1] <= r_wend_pipe[0];
      r_last_pipe[1] <= r_last_pipe[0];
    end
  end

  for (genvar g = 0; g < NB_PORTS; g++) begin : g_cnt
    sat_counter #(.W(CNT_WIDTH)) u_xfer (
      .clk(clk), .rst(rst), .i_clr(clear | w_start_acc), .i_en(r_s0_fire[g]),
      .o_cnt(xfer_count[g]), .o_full(w_full[g])
    );
    sat_counter #(.W(CNT_WIDTH)) u_zero (
      .clk(clk), .rst(rst), .i_clr(clear | w_start_acc), .i_en(r_s0_zf[g]),
      .o_cnt(zero_count[g]), .o_full(w_full[NB_PORTS+g])
    );
  end

  assign w_e_sum = ACC_WIDTH'(sat_add(64'(r_energy),  64'(r_s1_cost), ACC_WIDTH));
  assign w_w_sum = ACC_WIDTH'(sat_add(64'(r_win_acc), 64'(r_s1_cost), ACC_WIDTH));

  // s2: accumulate; a window closes on its end tag, or on the last
  // sample of the run (partial window flushed alongside done).
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_energy     <= '0;
      r_win_acc    <= '0;
      r_win_energy <= '0;
      r_sat        <= 1'b0;
      r_done       <= 1'b0;
      r_wv         <= 1'b0;
    end else begin
      r_energy <= w_e_sum;
      r_sat    <= r_sat | (&w_e_sum) | (|w_full);
      r_done   <= r_last_pipe[1];
      if (r_wend_pipe[1] || (r_last_pipe[1] && w_win_on)) begin
        r_win_energy <= w_w_sum;
        r_win_acc    <= '0;
        r_wv         <= 1'b1;
      end else begin
        r_win_acc    <= w_w_sum;
        r_wv         <= 1'b0;
      end
    end
  end

  assign running       = r_running;
  assign done          = r_done;
  assign energy_total  = r_energy;
  assign saturated     = r_sat;
  assign window_energy = r_win_energy;
  assign window_valid  = r_wv;

endmodule
